// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// A small synchronous FIFO that buffers ALU results between the ALU and its
// consumer. Each entry holds the result value, the {n,z,v,c} flags and the
// illegal-op error bit (hata). The head entry is presented on the registered
// outputs with a valid/ready handshake. There is no fall-through, so an entry
// pushed at edge k becomes visible after edge k.
//
// Side-band status:
//   err_sticky : latches when any accepted entry carried hata=1. Cleared by
//                err_clr. A new error in the same cycle as err_clr wins.
//   drop_cnt   : saturating count of pushes lost because the FIFO was full.
//
// Parameters
//   XLEN  : result width. Must match the upstream ALU.
//   DEPTH : number of entries. Must be a power of two and at least 2.
//
// Ports
//   clk        in   clock. All state changes on its rising edge.
//   rst        in   synchronous, active-high reset.
//   in_valid   in   upstream result present this cycle.
//   in_s       in   result value.
//   in_nzvc    in   result flags {n,z,v,c}.
//   in_hata    in   illegal-op error bit.
//   in_ready   out  FIFO can accept a push. Decoded from registered count only.
//   out_valid  out  head entry available.
//   out_ready  in   consumer takes the head entry when out_valid=1.
//   out_s      out  head entry result.
//   out_nzvc   out  head entry flags.
//   out_hata   out  head entry error bit.
//   count      out  number of stored entries (0..DEPTH).
//   err_sticky out  sticky record of an accepted hata entry.
//   err_clr    in   clears err_sticky.
//   drop_cnt   out  saturating count of dropped pushes.
// -----------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_s,
  input  logic [3:0]                 in_nzvc,
  input  logic                       in_hata,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_s,
  output logic [3:0]                 out_nzvc,
  output logic                       out_hata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_sticky,
  input  logic                       err_clr,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] s;
    logic [3:0]      nzvc;
    logic            hata;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic            push;
  logic            pop;
  logic            drop;
  entry_t          head;

  // Handshake decode. in_ready and out_valid depend only on the registered
  // count, so out_ready never reaches in_ready combinationally. A full FIFO
  // refuses the push even when a pop happens in the same cycle.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop      = in_valid & ~in_ready;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset. The valid state lives in the
  // pointers and count, so stale data is never presented as valid. Leaving
  // the array unreset also lets it map onto plain registers or RAM.
  // NOTE: sequential state is written with non-blocking assignments, so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{s: in_s, nzvc: in_nzvc, hata: in_hata};
    end
  end

  // Pointers are AW bits wide. Because DEPTH is a power of two, the natural
  // roll-over gives the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
    end
  end

  // Only accepted pushes can raise the error. Setting has priority over
  // err_clr in the same cycle, so a fresh error is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (push && in_hata) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

  // The drop counter saturates at 255 instead of wrapping, so a long overflow
  // burst cannot read back as a small number.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign head     = mem[rd_ptr];
  assign out_s    = head.s;
  assign out_nzvc = head.nzvc;
  assign out_hata = head.hata;
  assign count    = count_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo
//
// Directed bench for alu_result_fifo (XLEN=32, DEPTH=4). Inputs change on the
// falling edge. Outputs are checked on the falling edge, after the rising edge
// that updated them has settled. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_result_fifo;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [XLEN-1:0]   in_s;
  logic [3:0]        in_nzvc;
  logic              in_hata;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_s;
  logic [3:0]        out_nzvc;
  logic              out_hata;
  logic [2:0]        count;
  logic              err_sticky;
  logic              err_clr;
  logic [7:0]        drop_cnt;

  int checks   = 0;
  int failures = 0;

  alu_result_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_s       (in_s),
    .in_nzvc    (in_nzvc),
    .in_hata    (in_hata),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_nzvc   (out_nzvc),
    .out_hata   (out_hata),
    .count      (count),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: let the rising edge act, then return on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_s = '0; in_nzvc = '0; in_hata = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_count",   32'(count),      32'd0);
    check("rst_ovalid",  32'(out_valid),  32'd0);
    check("rst_iready",  32'(in_ready),   32'd1);
    check("rst_err",     32'(err_sticky), 32'd0);
    check("rst_drop",    32'(drop_cnt),   32'd0);

    // Basic push of three entries, then pop all three.
    in_valid = 1'b1;
    in_s = 32'h11; step();
    in_s = 32'h22; step();
    in_s = 32'h33; step();
    in_valid = 1'b0;
    check("b_count",  32'(count),     32'd3);
    check("b_head",   out_s,          32'h11);
    check("b_iready", 32'(in_ready),  32'd1);
    check("b_ovalid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b_pop%0d", i), out_s, 32'h11 * (i + 1));
      step();
    end
    check("b_empty_count",  32'(count),     32'd0);
    check("b_empty_ovalid", 32'(out_valid), 32'd0);

    // A pop on an empty FIFO is ignored.
    step();
    check("pop_empty_count", 32'(count), 32'd0);

    // Push into empty with out_ready=1: push only, no pop.
    in_valid = 1'b1; in_s = 32'h44; step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pe_count", 32'(count), 32'd1);
    check("pe_head",  out_s,      32'h44);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("pe_drain", 32'(count), 32'd0);

    // Overflow: the fifth push is dropped.
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_s = 32'(i);
      step();
      if (i == 4) begin
        check("ov_count4",  32'(count),    32'd4);
        check("ov_iready4", 32'(in_ready), 32'd0);
      end
    end
    check("ov_count5", 32'(count),    32'd4);
    check("ov_drop1",  32'(drop_cnt), 32'd1);
    check("ov_head",   out_s,         32'd1);

    // When full, a simultaneous push and pop pops, and the push is dropped.
    in_s = 32'h99; out_ready = 1'b1; step();
    out_ready = 1'b0;
    check("fp_count", 32'(count),    32'd3);
    check("fp_drop",  32'(drop_cnt), 32'd2);
    check("fp_head",  out_s,         32'd2);

    // Refill, then overflow 300 times: the counter saturates.
    in_s = 32'h55; step();
    check("rf_count", 32'(count), 32'd4);
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    check("sat_drop", 32'(drop_cnt), 32'd255);

    // Drain. The dropped 0x99 must not appear.
    out_ready = 1'b1;
    check("dr0", out_s, 32'd2);    step();
    check("dr1", out_s, 32'd3);    step();
    check("dr2", out_s, 32'd4);    step();
    check("dr3", out_s, 32'h55);   step();
    out_ready = 1'b0;
    check("dr_count", 32'(count), 32'd0);

    // Steady state at count=2: stream 0..9 across the pointer wrap.
    in_valid = 1'b1;
    in_s = 32'd0; step();
    in_s = 32'd1; step();
    out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      in_s = 32'(i);
      check($sformatf("ss_out%0d", i - 2), out_s, 32'(i - 2));
      step();
      check($sformatf("ss_cnt%0d", i - 2), 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    check("ss_out8", out_s, 32'd8); step();
    check("ss_out9", out_s, 32'd9); step();
    out_ready = 1'b0;
    check("ss_empty", 32'(count), 32'd0);

    // Error flag handling.
    in_valid = 1'b1; in_s = 32'hA; in_nzvc = 4'b0100; in_hata = 1'b1; step();
    in_valid = 1'b0;
    check("er_set",  32'(err_sticky), 32'd1);
    check("er_hata", 32'(out_hata),   32'd1);
    check("er_nzvc", 32'(out_nzvc),   32'h4);
    in_valid = 1'b1; in_s = 32'hB; err_clr = 1'b1; step();
    in_valid = 1'b0;
    check("er_setwins", 32'(err_sticky), 32'd1);
    step();
    err_clr = 1'b0; in_hata = 1'b0; in_nzvc = 4'b0000;
    check("er_clr", 32'(err_sticky), 32'd0);

    // A dropped hata entry must not set the flag (count is 2 here).
    in_valid = 1'b1; in_s = 32'hC; step();
    in_s = 32'hD; step();
    check("dh_full", 32'(count), 32'd4);
    in_hata = 1'b1; in_s = 32'hE; step();
    in_valid = 1'b0; in_hata = 1'b0;
    check("dh_err", 32'(err_sticky), 32'd0);

    // Make it full with err_sticky set, then reset with traffic present.
    out_ready = 1'b1; step(); out_ready = 1'b0;
    in_valid = 1'b1; in_hata = 1'b1; in_s = 32'hF; step();
    check("pr_count", 32'(count),      32'd4);
    check("pr_err",   32'(err_sticky), 32'd1);
    rst = 1'b1; out_ready = 1'b1; step();
    rst = 1'b0; in_valid = 1'b0; in_hata = 1'b0; out_ready = 1'b0;
    check("mr_count",  32'(count),      32'd0);
    check("mr_ovalid", 32'(out_valid),  32'd0);
    check("mr_iready", 32'(in_ready),   32'd1);
    check("mr_err",    32'(err_sticky), 32'd0);
    check("mr_drop",   32'(drop_cnt),   32'd0);

    // The FIFO works again after the reset.
    in_valid = 1'b1; in_s = 32'h77; step();
    in_valid = 1'b0;
    check("pr2_count", 32'(count), 32'd1);
    check("pr2_head",  out_s,      32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
